// File: rtl/distribuidor_cartas.sv
// Card dealer/scheduler: sequences deck reset and shuffle, owns the deck read pointer
// and shares the deck between player and dealer with round-robin arbitration.
module distribuidor_cartas #(
    parameter int RESHUFFLE_AT    = 40,
    parameter int SHUFFLE_TIMEOUT = 2047
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_round,
    input  logic       req_player,
    input  logic       req_dealer,
    output logic       ack_player,
    output logic       ack_dealer,
    output logic [3:0] card_value,
    output logic       deck_rst,
    output logic       shuffle_start,
    input  logic       shuffle_ok,
    output logic [5:0] deck_addr,
    input  logic [3:0] deck_q,
    output logic       ready,
    output logic [5:0] cards_left,
    output logic       error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECK_RST  = 3'd1;
    localparam logic [2:0] S_SHUF_REQ  = 3'd2;
    localparam logic [2:0] S_SHUF_WAIT = 3'd3;
    localparam logic [2:0] S_READY     = 3'd4;
    localparam logic [2:0] S_FETCH     = 3'd5;
    localparam logic [2:0] S_ACK       = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam logic [5:0]  DECK_SIZE  = 6'd52;
    localparam logic [5:0]  RESHUF_PTR = 6'(RESHUFFLE_AT);
    localparam logic [10:0] TIMEOUT    = 11'(SHUFFLE_TIMEOUT);
    localparam logic        GRANT_P    = 1'b0;
    localparam logic        GRANT_D    = 1'b1;

    logic [2:0]  state_q, state_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  addr_q, addr_d;
    logic [3:0]  card_q, card_d;
    logic [10:0] timer_q, timer_d;
    logic        shuffled_q, shuffled_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        any_req;
    logic        pick;

    assign any_req = req_player | req_dealer;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        pick = GRANT_D;
        if (req_player && req_dealer) pick = ~last_grant_q;
        else if (req_player)          pick = GRANT_P;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        card_d       = card_q;
        timer_d      = timer_q;
        shuffled_d   = shuffled_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        case (state_q)
            S_IDLE: begin
                if (start_round) state_d = S_DECK_RST;
            end
            S_DECK_RST: begin
                ptr_d   = 6'd0;
                addr_d  = 6'd0;
                state_d = S_SHUF_REQ;
            end
            S_SHUF_REQ: begin
                timer_d = 11'd0;
                state_d = S_SHUF_WAIT;
            end
            S_SHUF_WAIT: begin
                if (shuffle_ok) begin
                    shuffled_d = 1'b1;
                    state_d    = S_READY;
                end else if (timer_q == TIMEOUT) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 11'd1;
                end
            end
            S_READY: begin
                // An exhausted deck reshuffles first; the request stays pending.
                if (start_round && (ptr_q >= RESHUF_PTR || !shuffled_q)) begin
                    state_d = S_DECK_RST;
                end else if (any_req && ptr_q == DECK_SIZE) begin
                    state_d = S_DECK_RST;
                end else if (any_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = ptr_q;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                card_d  = deck_q;
                ptr_d   = ptr_q + 6'd1;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_READY;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 6'd0;
            addr_q       <= 6'd0;
            card_q       <= 4'd0;
            timer_q      <= 11'd0;
            shuffled_q   <= 1'b0;
            last_grant_q <= GRANT_D;
            grant_q      <= GRANT_P;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            card_q       <= card_d;
            timer_q      <= timer_d;
            shuffled_q   <= shuffled_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    assign ack_player    = (state_q == S_ACK) && (grant_q == GRANT_P);
    assign ack_dealer    = (state_q == S_ACK) && (grant_q == GRANT_D);
    assign card_value    = card_q;
    assign deck_rst      = (state_q == S_DECK_RST);
    assign shuffle_start = (state_q == S_SHUF_REQ);
    assign deck_addr     = addr_q;
    assign ready         = (state_q == S_READY);
    assign cards_left    = DECK_SIZE - ptr_q;
    assign error         = (state_q == S_ERROR);

endmodule

// File: tb/tb_distribuidor_cartas.sv
// Directed bench for distribuidor_cartas with a behavioural deck and shuffle responder.
module tb_distribuidor_cartas;

    logic       clock = 1'b0;
    logic       reset, start_round, req_player, req_dealer, shuffle_ok;
    logic       ack_player, ack_dealer, deck_rst, shuffle_start, ready, error;
    logic [3:0] card_value, deck_q;
    logic [5:0] deck_addr, cards_left;

    int n_vec = 0;
    int n_err = 0;
    int dealt = 0;
    int grants = 0;
    int shuf_cnt = 0;
    int shuf_delay = 300;
    bit shuf_en = 1'b1;
    int both_cnt = 0;
    int ack_cnt = 0;
    int drst_cnt = 0;

    always #5 clock = ~clock;

    distribuidor_cartas #(.RESHUFFLE_AT(40), .SHUFFLE_TIMEOUT(2047)) dut (
        .clock(clock), .reset(reset), .start_round(start_round),
        .req_player(req_player), .req_dealer(req_dealer),
        .ack_player(ack_player), .ack_dealer(ack_dealer), .card_value(card_value),
        .deck_rst(deck_rst), .shuffle_start(shuffle_start), .shuffle_ok(shuffle_ok),
        .deck_addr(deck_addr), .deck_q(deck_q), .ready(ready),
        .cards_left(cards_left), .error(error)
    );

    function automatic logic [3:0] card_of(input int a);
        return 4'(((a * 7 + 3) % 11) + 1);
    endfunction

    always_comb deck_q = card_of(int'(deck_addr));

    // Shuffle engine model: answers shuffle_start with a one-cycle ok after a delay.
    always @(posedge clock) begin
        if (shuffle_start && shuf_en) shuf_cnt <= shuf_delay;
        else if (shuf_cnt > 0)        shuf_cnt <= shuf_cnt - 1;
    end
    assign shuffle_ok = (shuf_cnt == 1);

    always @(posedge clock) begin
        if (ack_player && ack_dealer)  both_cnt <= both_cnt + 1;
        if (ack_player || ack_dealer)  ack_cnt  <= ack_cnt + 1;
        if (deck_rst)                  drst_cnt <= drst_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start_round = 1'b1;
        @(posedge clock); #1 start_round = 1'b0;
    endtask

    task automatic expect_shuffle(input string tag);
        int k;
        k = 0;
        @(negedge clock);
        while (!deck_rst && k < 20) begin @(negedge clock); k++; end
        check_val({tag, "_drst"}, deck_rst, 1);
        @(negedge clock);
        check_val({tag, "_drst_1cyc"}, deck_rst, 0);
        check_val({tag, "_sstart"}, shuffle_start, 1);
        @(negedge clock);
        check_val({tag, "_sstart_1cyc"}, shuffle_start, 0);
        k = 0;
        while (!ready && k < 400) begin @(negedge clock); k++; end
        check_val({tag, "_ready"}, ready, 1);
        check_val({tag, "_left"}, cards_left, 52);
        check_val({tag, "_err"}, error, 0);
        dealt = 0;
    endtask

    task automatic deal(input bit who_d, input string tag, input int budget, output int lat);
        int k;
        k = 0;
        @(posedge clock); #1;
        if (who_d) req_dealer = 1'b1; else req_player = 1'b1;
        @(negedge clock);
        while (!(ack_player || ack_dealer) && k < budget) begin @(negedge clock); k++; end
        lat = k;
        check_val({tag, "_ack"}, who_d ? ack_dealer : ack_player, 1);
        check_val({tag, "_card"}, card_value, card_of(dealt));
        check_val({tag, "_addr"}, deck_addr, dealt);
        check_val({tag, "_left"}, cards_left, 51 - dealt);
        dealt++;
        grants++;
        @(posedge clock); #1;
        req_player = 1'b0;
        req_dealer = 1'b0;
    endtask

    initial begin
        int lat, k, d0;
        reset = 1'b1; start_round = 1'b0; req_player = 1'b0; req_dealer = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_val("rst_ready", ready, 0);
        check_val("rst_error", error, 0);
        check_val("rst_left", cards_left, 52);
        check_val("rst_addr", deck_addr, 0);
        check_val("rst_hs", {deck_rst, shuffle_start, ack_player, ack_dealer}, 0);
        check_val("rst_card", card_value, 0);

        // 1: first shuffle with a slow shuffle engine
        shuf_delay = 300;
        pulse_start();
        expect_shuffle("t1");

        // 2: single player request, two-cycle latency
        deal(1'b0, "t2", 10, lat);
        check_val("t2_latency", lat, 2);

        // 3: contention right after reset alternates starting with player
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        shuf_delay = 5;
        pulse_start();
        expect_shuffle("t3s");
        @(posedge clock); #1 req_player = 1'b1; req_dealer = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            @(negedge clock);
            while (!(ack_player || ack_dealer) && k < 8) begin @(negedge clock); k++; end
            check_val("t3_ackp", ack_player, (i % 2 == 0));
            check_val("t3_ackd", ack_dealer, (i % 2 == 1));
            check_val("t3_card", card_value, card_of(dealt));
            dealt++;
            grants++;
        end
        @(posedge clock); #1 req_player = 1'b0; req_dealer = 1'b0;

        // 4: no reshuffle at 39 dealt, reshuffle at 40
        while (dealt < 39) deal(dealt[0], "t4d", 10, lat);
        d0 = drst_cnt;
        pulse_start();
        repeat (3) @(negedge clock);
        check_val("t4_noop_ready", ready, 1);
        check_val("t4_noop_drst", drst_cnt, d0);
        check_val("t4_noop_left", cards_left, 13);
        deal(1'b0, "t4e", 10, lat);
        pulse_start();
        expect_shuffle("t4s");

        // 5: exhaust the deck, then a request triggers an automatic reshuffle
        while (dealt < 52) deal(1'b1, "t5d", 10, lat);
        @(negedge clock);
        check_val("t5_empty", cards_left, 0);
        d0 = drst_cnt;
        dealt = 0;
        deal(1'b1, "t5auto", 400, lat);
        check_val("t5_drst_cnt", drst_cnt, d0 + 1);

        // 6: shuffle never completes
        d0 = ack_cnt;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        shuf_en = 1'b0;
        pulse_start();
        k = 0;
        @(negedge clock);
        while (!shuffle_start && k < 10) begin @(negedge clock); k++; end
        check_val("t6_sstart", shuffle_start, 1);
        #1 req_player = 1'b1;
        repeat (2000) @(negedge clock);
        check_val("t6_err_early", error, 0);
        k = 0;
        while (!error && k < 100) begin @(negedge clock); k++; end
        check_val("t6_err", error, 1);
        pulse_start();
        repeat (3) @(negedge clock);
        check_val("t6_sticky", error, 0 + 1);
        check_val("t6_no_ack", ack_cnt, d0);
        check_val("t6_ready", ready, 0);
        @(posedge clock); #1 reset = 1'b1; req_player = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_val("t6_clr_err", error, 0);
        check_val("t6_clr_left", cards_left, 52);
        repeat (3) @(negedge clock);
        check_val("t6_idle", {ready, deck_rst, shuffle_start}, 0);

        // Reset while a fetch is in flight drops the ack and the pointer advance
        shuf_en = 1'b1;
        pulse_start();
        expect_shuffle("t7s");
        d0 = ack_cnt;
        @(posedge clock); #1 req_player = 1'b1;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; req_player = 1'b0;
        @(negedge clock);
        check_val("t7_left", cards_left, 52);
        repeat (3) @(negedge clock);
        check_val("t7_no_ack", ack_cnt, d0);
        check_val("t7_ready", ready, 0);

        repeat (2) @(negedge clock);
        check_val("never_both_acks", both_cnt, 0);
        check_val("one_ack_per_grant", ack_cnt, grants);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
